// File: rtl/mul_unit_pkg.sv
// Shared definitions for the multiply functional unit: unit encodings,
// opcode constants, pipeline depth and per-stage payload structs.
package mul_unit_pkg;

  // Functional-unit select encodings used by Issue
  typedef enum logic [1:0] {
    FU_ALU_MISC = 2'b00,
    FU_MEM      = 2'b01,
    FU_MULT     = 2'b10,
    FU_NONE     = 2'b11
  } fu_e;

  localparam logic [5:0] FUNCT_MULT = 6'b011000;

  localparam int unsigned MUL_LATENCY = 4;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned PP_W   = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned REG_W  = 5;

  // S1: operand magnitudes and result sign
  typedef struct packed {
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic              neg;
    logic [REG_W-1:0]  regdest;
    logic              writereg;
  } s1_t;

  // S2: four 16x16 partial products
  typedef struct packed {
    logic [PP_W-1:0]  pp_ll;
    logic [PP_W-1:0]  pp_lh;
    logic [PP_W-1:0]  pp_hl;
    logic [PP_W-1:0]  pp_hh;
    logic             neg;
    logic [REG_W-1:0] regdest;
    logic             writereg;
  } s2_t;

  // S3: unsigned 64-bit magnitude product
  typedef struct packed {
    logic [PROD_W-1:0] sum;
    logic              neg;
    logic [REG_W-1:0]  regdest;
    logic              writereg;
  } s3_t;

  // S4: final signed/unsigned product presented to writeback
  typedef struct packed {
    logic [PROD_W-1:0] product;
    logic [REG_W-1:0]  regdest;
    logic              writereg;
  } s4_t;

  // Two's-complement magnitude when take_abs is set; 0x80000000 maps to itself
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x,
                                                  input logic              take_abs);
    return take_abs ? (~x + DATA_W'(1)) : x;
  endfunction

endpackage

// File: rtl/mul_unit_stage_reg.sv
// mul_stage_reg: one pipeline stage register (valid bit + payload) with a
// hold enable and synchronous active-high reset.
//   clock, reset       : clock and synchronous reset (clears valid and data)
//   hold               : keep current contents this edge
//   valid_in, data_in  : next stage contents
//   valid, data        : registered stage contents
module mul_stage_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hold,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (!hold) begin
      valid <= valid_in;
      data  <= data_in;
    end
  end

endmodule

// File: rtl/mul_unit.sv
// mul_unit: 4-stage pipelined 32x32 -> 64 multiplier downstream of Issue.
//   clock, reset          : system clock, synchronous active-high reset
//   iss_*                 : operation from Issue (accepted when not busy)
//   wb_mul_grant          : writeback consumes the presented result
//   mul_busy              : combinational; pipe frozen, no accept
//   mul_wb_*              : registered result (S4) to writeback
//   mul_sb_clear/addr     : combinational retire pulse to the scoreboard
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iss_mul_oper,
  input  logic [31:0] iss_ex_rega,
  input  logic [31:0] iss_ex_regb,
  input  logic        iss_ex_unsig,
  input  logic [4:0]  iss_ex_regdest,
  input  logic        iss_ex_writereg,
  input  logic        wb_mul_grant,
  output logic        mul_busy,
  output logic        mul_wb_valid,
  output logic [31:0] mul_wb_lo,
  output logic [31:0] mul_wb_hi,
  output logic [4:0]  mul_wb_regdest,
  output logic        mul_wb_writereg,
  output logic        mul_sb_clear,
  output logic [4:0]  mul_sb_addr
);

  // The stage count is fixed; a mismatched LATENCY is a configuration error
  if (LATENCY != MUL_LATENCY) begin : g_latency_check
    $error("mul_unit implements exactly %0d stages", MUL_LATENCY);
  end

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  s4_t s4_d, s4_q;
  logic s1_valid, s2_valid, s3_valid, s4_valid;
  logic hold;

  // A presented but ungranted result freezes the whole pipe
  assign hold     = s4_valid & ~wb_mul_grant;
  assign mul_busy = hold;

  // S1: operand capture as magnitudes plus result sign
  always_comb begin
    s1_d          = '0;
    s1_d.neg      = (iss_ex_rega[DATA_W-1] ^ iss_ex_regb[DATA_W-1]) & ~iss_ex_unsig;
    s1_d.mag_a    = magnitude(iss_ex_rega, iss_ex_rega[DATA_W-1] & ~iss_ex_unsig);
    s1_d.mag_b    = magnitude(iss_ex_regb, iss_ex_regb[DATA_W-1] & ~iss_ex_unsig);
    s1_d.regdest  = iss_ex_regdest;
    s1_d.writereg = iss_ex_writereg;
  end

  // S2: 16x16 partial products, widened so no bits are lost
  always_comb begin
    s2_d          = '0;
    s2_d.pp_ll    = PP_W'(s1_q.mag_a[HALF_W-1:0])      * PP_W'(s1_q.mag_b[HALF_W-1:0]);
    s2_d.pp_lh    = PP_W'(s1_q.mag_a[HALF_W-1:0])      * PP_W'(s1_q.mag_b[DATA_W-1:HALF_W]);
    s2_d.pp_hl    = PP_W'(s1_q.mag_a[DATA_W-1:HALF_W]) * PP_W'(s1_q.mag_b[HALF_W-1:0]);
    s2_d.pp_hh    = PP_W'(s1_q.mag_a[DATA_W-1:HALF_W]) * PP_W'(s1_q.mag_b[DATA_W-1:HALF_W]);
    s2_d.neg      = s1_q.neg;
    s2_d.regdest  = s1_q.regdest;
    s2_d.writereg = s1_q.writereg;
  end

  // S3: recombine partial products into the 64-bit magnitude
  always_comb begin
    s3_d          = '0;
    s3_d.sum      = PROD_W'(s2_q.pp_ll)
                  + (PROD_W'(s2_q.pp_lh) << HALF_W)
                  + (PROD_W'(s2_q.pp_hl) << HALF_W)
                  + (PROD_W'(s2_q.pp_hh) << DATA_W);
    s3_d.neg      = s2_q.neg;
    s3_d.regdest  = s2_q.regdest;
    s3_d.writereg = s2_q.writereg;
  end

  // S4: apply sign
  always_comb begin
    s4_d          = '0;
    s4_d.product  = s3_q.neg ? (~s3_q.sum + PROD_W'(1)) : s3_q.sum;
    s4_d.regdest  = s3_q.regdest;
    s4_d.writereg = s3_q.writereg;
  end

  mul_stage_reg #(.WIDTH($bits(s1_t))) u_s1 (
    .clock    (clock),
    .reset    (reset),
    .hold     (hold),
    .valid_in (iss_mul_oper),
    .data_in  (s1_d),
    .valid    (s1_valid),
    .data     (s1_q)
  );

  mul_stage_reg #(.WIDTH($bits(s2_t))) u_s2 (
    .clock    (clock),
    .reset    (reset),
    .hold     (hold),
    .valid_in (s1_valid),
    .data_in  (s2_d),
    .valid    (s2_valid),
    .data     (s2_q)
  );

  mul_stage_reg #(.WIDTH($bits(s3_t))) u_s3 (
    .clock    (clock),
    .reset    (reset),
    .hold     (hold),
    .valid_in (s2_valid),
    .data_in  (s3_d),
    .valid    (s3_valid),
    .data     (s3_q)
  );

  mul_stage_reg #(.WIDTH($bits(s4_t))) u_s4 (
    .clock    (clock),
    .reset    (reset),
    .hold     (hold),
    .valid_in (s3_valid),
    .data_in  (s4_d),
    .valid    (s4_valid),
    .data     (s4_q)
  );

  assign mul_wb_valid    = s4_valid;
  assign mul_wb_lo       = s4_q.product[DATA_W-1:0];
  assign mul_wb_hi       = s4_q.product[PROD_W-1:DATA_W];
  assign mul_wb_regdest  = s4_q.regdest;
  assign mul_wb_writereg = s4_q.writereg;

  // Retire pulse regardless of writereg so the scoreboard entry always clears
  assign mul_sb_clear = s4_valid & wb_mul_grant;
  assign mul_sb_addr  = s4_q.regdest;

endmodule

// File: tb/tb_mul_unit.sv
// Directed self-checking bench for mul_unit.
module tb_mul_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iss_mul_oper = 1'b0;
  logic [31:0] iss_ex_rega = '0;
  logic [31:0] iss_ex_regb = '0;
  logic        iss_ex_unsig = 1'b0;
  logic [4:0]  iss_ex_regdest = '0;
  logic        iss_ex_writereg = 1'b0;
  logic        wb_mul_grant = 1'b1;
  logic        mul_busy;
  logic        mul_wb_valid;
  logic [31:0] mul_wb_lo;
  logic [31:0] mul_wb_hi;
  logic [4:0]  mul_wb_regdest;
  logic        mul_wb_writereg;
  logic        mul_sb_clear;
  logic [4:0]  mul_sb_addr;

  mul_unit #(.LATENCY(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .iss_mul_oper    (iss_mul_oper),
    .iss_ex_rega     (iss_ex_rega),
    .iss_ex_regb     (iss_ex_regb),
    .iss_ex_unsig    (iss_ex_unsig),
    .iss_ex_regdest  (iss_ex_regdest),
    .iss_ex_writereg (iss_ex_writereg),
    .wb_mul_grant    (wb_mul_grant),
    .mul_busy        (mul_busy),
    .mul_wb_valid    (mul_wb_valid),
    .mul_wb_lo       (mul_wb_lo),
    .mul_wb_hi       (mul_wb_hi),
    .mul_wb_regdest  (mul_wb_regdest),
    .mul_wb_writereg (mul_wb_writereg),
    .mul_sb_clear    (mul_sb_clear),
    .mul_sb_addr     (mul_sb_addr)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    logic [31:0] hi;
    logic [31:0] lo;
  } ret_t;
  ret_t rq[$];

  // Retire log and Issue protocol monitor
  always @(negedge clock) begin
    if (!reset && mul_sb_clear)
      rq.push_back('{cyc, mul_sb_addr, mul_wb_hi, mul_wb_lo});
    if (iss_mul_oper && mul_busy)
      check("issue_while_busy", 64'd1, 64'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic unsig,
                       input logic [4:0] rd, input logic wr);
    iss_mul_oper    = 1'b1;
    iss_ex_rega     = a;
    iss_ex_regb     = b;
    iss_ex_unsig    = unsig;
    iss_ex_regdest  = rd;
    iss_ex_writereg = wr;
    tick();
    iss_mul_oper    = 1'b0;
  endtask

  task automatic check_idle_zero(input string pfx);
    check({pfx, "_valid"},    64'(mul_wb_valid),    64'd0);
    check({pfx, "_busy"},     64'(mul_busy),        64'd0);
    check({pfx, "_clear"},    64'(mul_sb_clear),    64'd0);
    check({pfx, "_lo"},       64'(mul_wb_lo),       64'd0);
    check({pfx, "_hi"},       64'(mul_wb_hi),       64'd0);
    check({pfx, "_regdest"},  64'(mul_wb_regdest),  64'd0);
    check({pfx, "_writereg"}, 64'(mul_wb_writereg), 64'd0);
  endtask

  // Isolated-op vectors with hand-computed products
  localparam int NV = 9;
  logic [31:0] va [NV] = '{32'h00000007, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                           32'h80000000, 32'h00010000, 32'h00000000, 32'h80000000,
                           32'hFFFFFFFF};
  logic [31:0] vb [NV] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                           32'h00000001, 32'h00010000, 32'hFFFFFFFB, 32'h00000002,
                           32'h00000002};
  logic        vu [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [4:0]  vr [NV] = '{5'd5, 5'd9, 5'd31, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7};
  logic        vw [NV] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] eh [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h40000000, 32'h00000000,
                           32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000001,
                           32'hFFFFFFFF};
  logic [31:0] el [NV] = '{32'hFFFFFFEB, 32'h00000001, 32'h00000000, 32'h00000001,
                           32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000,
                           32'hFFFFFFFE};

  initial begin
    int unsigned acc;

    // Reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_idle_zero("reset");

    // Isolated ops, grant held high
    wb_mul_grant = 1'b1;
    for (int i = 0; i < NV; i++) begin
      rq.delete();
      issue(va[i], vb[i], vu[i], vr[i], vw[i]);
      check($sformatf("v%0d_early_valid", i), 64'(mul_wb_valid), 64'd0);
      tick(); tick(); tick();
      @(negedge clock);
      check($sformatf("v%0d_valid", i),    64'(mul_wb_valid),    64'd1);
      check($sformatf("v%0d_hi", i),       64'(mul_wb_hi),       64'(eh[i]));
      check($sformatf("v%0d_lo", i),       64'(mul_wb_lo),       64'(el[i]));
      check($sformatf("v%0d_clear", i),    64'(mul_sb_clear),    64'd1);
      check($sformatf("v%0d_addr", i),     64'(mul_sb_addr),     64'(vr[i]));
      check($sformatf("v%0d_writereg", i), 64'(mul_wb_writereg), 64'(vw[i]));
      tick();
      @(negedge clock);
      check($sformatf("v%0d_after_valid", i), 64'(mul_wb_valid), 64'd0);
      check($sformatf("v%0d_retires", i), 64'(rq.size()), 64'd1);
    end

    // Back-to-back: 5 ops, results on consecutive cycles in order
    rq.delete();
    issue(32'd1, 32'd3, 1'b1, 5'd1, 1'b1);
    acc = cyc;
    for (int i = 2; i <= 5; i++) issue(32'(i), 32'd3, 1'b1, 5'(i), 1'b1);
    tick(); tick(); tick(); tick();
    check("b2b_count", 64'(rq.size()), 64'd5);
    for (int i = 0; i < 5 && i < rq.size(); i++) begin
      check($sformatf("b2b%0d_rd", i),  64'(rq[i].rd),  64'(i + 1));
      check($sformatf("b2b%0d_lo", i),  64'(rq[i].lo),  64'(3 * (i + 1)));
      check($sformatf("b2b%0d_hi", i),  64'(rq[i].hi),  64'd0);
      check($sformatf("b2b%0d_cyc", i), 64'(rq[i].cyc), 64'(acc + 3 + i));
    end

    // Backpressure: grant low when the first op reaches S4
    rq.delete();
    issue(32'd10, 32'd2, 1'b1, 5'd10, 1'b1);
    acc = cyc;
    issue(32'd11, 32'd2, 1'b1, 5'd11, 1'b1);
    issue(32'd12, 32'd2, 1'b1, 5'd12, 1'b1);
    wb_mul_grant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clock);
      check($sformatf("bp_stall%0d_valid", k), 64'(mul_wb_valid),   64'd1);
      check($sformatf("bp_stall%0d_busy", k),  64'(mul_busy),       64'd1);
      check($sformatf("bp_stall%0d_clear", k), 64'(mul_sb_clear),   64'd0);
      check($sformatf("bp_stall%0d_rd", k),    64'(mul_wb_regdest), 64'd10);
      check($sformatf("bp_stall%0d_lo", k),    64'(mul_wb_lo),      64'd20);
    end
    check("bp_no_retire", 64'(rq.size()), 64'd0);
    tick();
    wb_mul_grant = 1'b1;
    tick(); tick(); tick();
    check("bp_count", 64'(rq.size()), 64'd3);
    for (int i = 0; i < 3 && i < rq.size(); i++) begin
      check($sformatf("bp%0d_rd", i),  64'(rq[i].rd),  64'(10 + i));
      check($sformatf("bp%0d_lo", i),  64'(rq[i].lo),  64'(2 * (10 + i)));
      check($sformatf("bp%0d_cyc", i), 64'(rq[i].cyc), 64'(acc + 6 + i));
    end

    // Reset mid-flight: ops in S2/S3 discarded with no clear pulse
    rq.delete();
    issue(32'd4, 32'd5, 1'b1, 5'd20, 1'b1);
    issue(32'd6, 32'd5, 1'b1, 5'd21, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_idle_zero("rst_mid");
    tick(); tick(); tick(); tick();
    check("rst_mid_no_retire", 64'(rq.size()), 64'd0);
    issue(32'd6, 32'd7, 1'b1, 5'd22, 1'b1);
    tick(); tick(); tick();
    @(negedge clock);
    check("rst_post_valid", 64'(mul_wb_valid), 64'd1);
    check("rst_post_lo",    64'(mul_wb_lo),    64'd42);
    check("rst_post_rd",    64'(mul_sb_addr),  64'd22);
    check("rst_post_clear", 64'(mul_sb_clear), 64'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
